// File: rtl/i2c_target_pkg.sv
// Shared types and register map for the ADT7410-style I2C target.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK
    } state_e;

    localparam logic [7:0] REG_TEMP_MSB = 8'h00;
    localparam logic [7:0] REG_TEMP_LSB = 8'h01;
    localparam logic [7:0] REG_STATUS   = 8'h02;
    localparam logic [7:0] REG_CONFIG   = 8'h03;
    localparam logic [7:0] REG_ID       = 8'h0B;
    localparam logic [7:0] ID_VALUE     = 8'hCB;

    function automatic logic [7:0] reg_read(input logic [7:0]  ptr,
                                            input logic [15:0] shadow,
                                            input logic [7:0]  cfg);
        case (ptr)
            REG_TEMP_MSB: return shadow[15:8];
            REG_TEMP_LSB: return shadow[7:0];
            REG_STATUS:   return 8'h00;
            REG_CONFIG:   return cfg;
            REG_ID:       return ID_VALUE;
            default:      return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/i2c_target_filter.sv
// SCL/SDA conditioning: 2-FF synchronizer, FILTER_LEN-sample glitch filter,
// and edge / START / STOP detection on the filtered levels.
module i2c_target_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic Clk_i,
    input  logic Reset_i,
    input  logic SCL_i,
    input  logic SDA_i,
    output logic SclLevel_o,
    output logic SdaLevel_o,
    output logic SclRise_o,
    output logic SclFall_o,
    output logic Start_o,
    output logic Stop_o
);

    logic [1:0]            scl_sync_q, sda_sync_q;
    logic [FILTER_LEN-1:0] scl_hist_q, sda_hist_q;
    logic                  scl_filt_q, sda_filt_q;
    logic                  scl_prev_q, sda_prev_q;

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], SCL_i};
            sda_sync_q <= {sda_sync_q[0], SDA_i};
            scl_hist_q <= (scl_hist_q << 1) | FILTER_LEN'(scl_sync_q[1]);
            sda_hist_q <= (sda_hist_q << 1) | FILTER_LEN'(sda_sync_q[1]);
            // Level only moves once the whole history window agrees
            if (&scl_hist_q)       scl_filt_q <= 1'b1;
            else if (~|scl_hist_q) scl_filt_q <= 1'b0;
            if (&sda_hist_q)       sda_filt_q <= 1'b1;
            else if (~|sda_hist_q) sda_filt_q <= 1'b0;
            scl_prev_q <= scl_filt_q;
            sda_prev_q <= sda_filt_q;
        end
    end

    assign SclLevel_o = scl_filt_q;
    assign SdaLevel_o = sda_filt_q;
    assign SclRise_o  = scl_filt_q & ~scl_prev_q;
    assign SclFall_o  = ~scl_filt_q & scl_prev_q;
    // SCL must be high on both samples, so an SDA edge beside an SCL edge is data
    assign Start_o    = scl_filt_q & scl_prev_q & sda_prev_q & ~sda_filt_q;
    assign Stop_o     = scl_filt_q & scl_prev_q & ~sda_prev_q & sda_filt_q;

endmodule

// File: rtl/i2c_target_adt7410.sv
// I2C target emulating the ADT7410 register map (temperature, status, config, ID).
// Define I2C_TARGET_TIMEOUT_EN to release the bus after TIMEOUT_CYCLES of SCL low.
module i2c_target_adt7410
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]  ADDR           = 7'h48,
    parameter int unsigned FILTER_LEN     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        Clk_i,
    input  logic        Reset_i,
    input  logic        SCL_i,
    input  logic        SDA_i,
    output logic        SdaPullLow_o,
    input  logic [15:0] TempValue_i,
    output logic [7:0]  Config_o,
    output logic        RegWrite_o,
    output logic        Addressed_o
);

    logic scl_lvl, sda_lvl, scl_rise, scl_fall, start, stop;
    logic timeout_hit;

    i2c_target_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .Clk_i      (Clk_i),
        .Reset_i    (Reset_i),
        .SCL_i      (SCL_i),
        .SDA_i      (SDA_i),
        .SclLevel_o (scl_lvl),
        .SdaLevel_o (sda_lvl),
        .SclRise_o  (scl_rise),
        .SclFall_o  (scl_fall),
        .Start_o    (start),
        .Stop_o     (stop)
    );

    state_e      state_q;
    logic [3:0]  bit_cnt_q;
    logic [6:0]  shift_q;
    logic [7:0]  ptr_q;
    logic [15:0] shadow_q;
    logic [7:0]  config_q;
    logic        pull_q, addressed_q, regwrite_q, rw_q, first_q;
    logic [7:0]  rx_byte, rd_byte;

    assign rx_byte = {shift_q, sda_lvl};
    assign rd_byte = reg_read(ptr_q, shadow_q, config_q);

`ifdef I2C_TARGET_TIMEOUT_EN
    logic [31:0] to_cnt_q;

    always_ff @(posedge Clk_i) begin
        if (Reset_i || state_q == ST_IDLE || scl_lvl)
            to_cnt_q <= '0;
        else if (to_cnt_q != TIMEOUT_CYCLES)
            to_cnt_q <= to_cnt_q + 32'd1;
    end

    assign timeout_hit = (to_cnt_q == TIMEOUT_CYCLES) && (state_q != ST_IDLE);
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = scl_lvl ^ (TIMEOUT_CYCLES == 32'd0);
`endif

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= REG_TEMP_MSB;
            shadow_q    <= '0;
            config_q    <= '0;
            pull_q      <= 1'b0;
            addressed_q <= 1'b0;
            regwrite_q  <= 1'b0;
            rw_q        <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            regwrite_q <= 1'b0;
            if (start) begin
                state_q     <= ST_ADDR;
                bit_cnt_q   <= '0;
                pull_q      <= 1'b0;
                addressed_q <= 1'b0;
            end else if (stop || timeout_hit) begin
                state_q     <= ST_IDLE;
                pull_q      <= 1'b0;
                addressed_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR: if (scl_rise) begin
                        shift_q   <= rx_byte[6:0];
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_q <= '0;
                            if (rx_byte[7:1] == ADDR) begin
                                state_q <= ST_ADDR_ACK;
                                rw_q    <= rx_byte[0];
                                first_q <= 1'b1;
                                if (rx_byte[0]) shadow_q <= TempValue_i;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    // bit_cnt_q==0: first fall drives ACK; second fall ends the ACK clock
                    ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            pull_q      <= 1'b1;
                            addressed_q <= 1'b1;
                            bit_cnt_q   <= 4'd1;
                        end else begin
                            bit_cnt_q <= '0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                state_q <= ST_RD_BYTE;
                                shift_q <= rd_byte[6:0];
                                pull_q  <= ~rd_byte[7];
                            end else begin
                                state_q <= ST_WR_BYTE;
                                pull_q  <= 1'b0;
                            end
                        end
                    end
                    ST_WR_BYTE: if (scl_rise) begin
                        shift_q   <= rx_byte[6:0];
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_q <= '0;
                            state_q   <= ST_WR_ACK;
                            if (first_q) begin
                                ptr_q   <= rx_byte;
                                first_q <= 1'b0;
                            end else begin
                                if (ptr_q == REG_CONFIG) config_q <= rx_byte;
                                regwrite_q <= 1'b1;
                                ptr_q      <= ptr_q + 8'd1;
                            end
                        end
                    end
                    ST_RD_BYTE: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                state_q   <= ST_RD_ACK;
                                bit_cnt_q <= '0;
                                pull_q    <= 1'b0;
                            end else begin
                                shift_q <= {shift_q[5:0], 1'b0};
                                pull_q  <= ~shift_q[6];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_lvl) begin
                                state_q <= ST_IDLE;
                            end else begin
                                ptr_q     <= ptr_q + 8'd1;
                                bit_cnt_q <= 4'd1;
                            end
                        end else if (scl_fall && bit_cnt_q == 4'd1) begin
                            state_q   <= ST_RD_BYTE;
                            bit_cnt_q <= '0;
                            shift_q   <= rd_byte[6:0];
                            pull_q    <= ~rd_byte[7];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign SdaPullLow_o = pull_q;
    assign Config_o     = config_q;
    assign RegWrite_o   = regwrite_q;
    assign Addressed_o  = addressed_q;

endmodule

// File: tb/tb_i2c_target_adt7410.sv
// Bench for i2c_target_adt7410: bit-banged I2C master plus a register-map model.
module tb_i2c_target_adt7410;

    localparam int Q = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_m, sda_m, sda_bus;
    logic        pull;
    logic [15:0] temp;
    logic [7:0]  cfg;
    logic        rw, addrd;

    always #5 clk = ~clk;
    assign sda_bus = sda_m & ~pull;

    i2c_target_adt7410 #(
        .ADDR           (7'h48),
        .FILTER_LEN     (3),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .Clk_i        (clk),
        .Reset_i      (rst),
        .SCL_i        (scl_m),
        .SDA_i        (sda_bus),
        .SdaPullLow_o (pull),
        .TempValue_i  (temp),
        .Config_o     (cfg),
        .RegWrite_o   (rw),
        .Addressed_o  (addrd)
    );

    // register-map model of the target
    bit [7:0]  m_cfg, m_ptr;
    bit [15:0] m_shadow;
    bit        m_addr, m_active, m_first;
    int        m_rw = 0, rw_seen = 0;
    bit        exp_pull = 1'b0, chk_pull = 1'b0, strobe = 1'b0, watch_zero = 1'b0;
    int        checks = 0, failures = 0;

    bit        ack_v, a0, a1, a2;
    bit [7:0]  got_v, p_v, ad_v;
    int        n_v, op_v, rw0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [7:0] model_reg(input bit [7:0] a);
        case (a)
            8'h00:   return m_shadow[15:8];
            8'h01:   return m_shadow[7:0];
            8'h03:   return m_cfg;
            8'h0B:   return 8'hCB;
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit [7:0] pick_ptr();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h02;
            3: return 8'h03;
            4: return 8'h0B;
            5: return 8'hFE;
            6: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && rw === 1'b1) rw_seen++;
        if (chk_pull)   check("sda_pull", pull, exp_pull);
        if (watch_zero) check("sda_quiet", pull, 1'b0);
        if (strobe) begin
            check("addressed", addrd, m_addr);
            check("config", cfg, m_cfg);
            check("regwrite_count", rw_seen, m_rw);
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one SCL clock; SCL is low on entry and on exit
    task automatic bit_clk(input bit v, output bit s);
        tick(4);
        sda_m = v;
        tick(Q - 4);
        scl_m = 1'b1;
        tick(1);
        chk_pull = 1'b1;
        tick(10);
        s = sda_bus;
        strobe = 1'b1;
        tick(1);
        strobe = 1'b0;
        tick(Q - 12);
        chk_pull = 1'b0;
        scl_m = 1'b0;
    endtask

    task automatic start_cond();
        if (scl_m == 1'b0) begin
            tick(4);
            sda_m = 1'b1;
            tick(Q - 4);
            scl_m = 1'b1;
            tick(Q);
        end
        sda_m = 1'b0;
        m_addr = 1'b0;
        m_active = 1'b1;
        tick(Q);
        scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        tick(4);
        sda_m = 1'b0;
        tick(Q - 4);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        m_addr = 1'b0;
        m_active = 1'b0;
        tick(Q);
    endtask

    task automatic send_byte(input bit [7:0] b, input bit is_addr, output bit ack);
        bit s, match, exp_ack;
        match   = is_addr && (b[7:1] == 7'h48);
        exp_ack = is_addr ? match : m_active;
        exp_pull = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && m_active) begin
                if (is_addr) begin
                    if (match) begin
                        m_first = 1'b1;
                        if (b[0]) m_shadow = temp;
                    end
                end else if (m_first) begin
                    m_ptr = b;
                    m_first = 1'b0;
                end else begin
                    if (m_ptr == 8'h03) m_cfg = b;
                    m_rw++;
                    m_ptr++;
                end
            end
            bit_clk(b[i], s);
        end
        if (is_addr) begin
            m_active = match;
            m_addr   = match;
        end
        exp_pull = exp_ack;
        bit_clk(1'b1, s);
        ack = ~s;
        exp_pull = 1'b0;
    endtask

    task automatic recv_byte(input bit ack_it, output bit [7:0] got);
        bit s;
        bit [7:0] exp;
        exp = model_reg(m_ptr);
        for (int i = 7; i >= 0; i--) begin
            exp_pull = ~exp[i];
            bit_clk(1'b1, s);
            got[i] = s;
        end
        check("read_byte", got, exp);
        exp_pull = 1'b0;
        bit_clk(~ack_it, s);
        if (ack_it) m_ptr++;
        else m_active = 1'b0;
    endtask

    task automatic set_ptr_then_read(input bit [7:0] p);
        start_cond();
        send_byte(8'h90, 1'b1, ack_v);
        send_byte(p, 1'b0, ack_v);
        start_cond();
        send_byte(8'h91, 1'b1, ack_v);
    endtask

    initial begin
        rst = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        temp = 16'h0000;
        m_cfg = 8'h00; m_ptr = 8'h00; m_shadow = 16'h0; m_addr = 1'b0; m_active = 1'b0; m_first = 1'b0;
        tick(3);
        check("rst_pull", pull, 1'b0);
        check("rst_config", cfg, 8'h00);
        check("rst_regwrite", rw, 1'b0);
        check("rst_addressed", addrd, 1'b0);
        rst = 1'b0;
        tick(20);

        // config write
        rw0 = rw_seen;
        start_cond();
        send_byte(8'h90, 1'b1, a0);
        send_byte(8'h03, 1'b0, a1);
        send_byte(8'h20, 1'b0, a2);
        stop_cond();
        check("cfg_ack0", a0, 1'b1);
        check("cfg_ack1", a1, 1'b1);
        check("cfg_ack2", a2, 1'b1);
        check("cfg_value", cfg, 8'h20);
        check("cfg_pulses", rw_seen - rw0, 1);
        check("cfg_addressed_after_stop", addrd, 1'b0);

        // pointer write, repeated start, two-byte read
        temp = 16'h0C80;
        set_ptr_then_read(8'h00);
        check("rd_addr_ack", ack_v, 1'b1);
        recv_byte(1'b1, got_v);
        check("rd_msb", got_v, 8'h0C);
        recv_byte(1'b0, got_v);
        check("rd_lsb", got_v, 8'h80);
        stop_cond();

        // temperature changes between MSB and LSB
        set_ptr_then_read(8'h00);
        recv_byte(1'b1, got_v);
        check("snap_msb", got_v, 8'h0C);
        temp = 16'h0D00;
        recv_byte(1'b0, got_v);
        check("snap_lsb", got_v, 8'h80);
        stop_cond();

        // foreign address is ignored
        watch_zero = 1'b1;
        start_cond();
        send_byte(8'h92, 1'b1, ack_v);
        check("foreign_nack", ack_v, 1'b0);
        send_byte(8'h00, 1'b0, ack_v);
        check("foreign_data_nack", ack_v, 1'b0);
        stop_cond();
        watch_zero = 1'b0;
        start_cond();
        send_byte(8'h90, 1'b1, ack_v);
        check("after_foreign_ack", ack_v, 1'b1);
        stop_cond();

        // ID register and pointer wrap
        set_ptr_then_read(8'h0B);
        recv_byte(1'b0, got_v);
        check("id_value", got_v, 8'hCB);
        stop_cond();
        set_ptr_then_read(8'hFF);
        recv_byte(1'b1, got_v);
        check("wrap_ff", got_v, 8'h00);
        recv_byte(1'b0, got_v);
        check("wrap_msb", got_v, 8'h0D);
        stop_cond();

        // reset during a read byte whose first bit is 0
        temp = 16'h0C80;
        set_ptr_then_read(8'h00);
        tick(10);
        check("pull_before_reset", pull, 1'b1);
        rst = 1'b1;
        tick(1);
        check("pull_after_reset", pull, 1'b0);
        rst = 1'b0;
        m_cfg = 8'h00; m_ptr = 8'h00; m_addr = 1'b0; m_active = 1'b0; m_first = 1'b0;
        check("config_after_reset", cfg, 8'h00);
        exp_pull = 1'b0;
        bit_clk(1'b0, ack_v);
        bit_clk(1'b1, ack_v);
        stop_cond();

`ifdef I2C_TARGET_TIMEOUT_EN
        // SCL stuck low while the target drives a 0 data bit
        set_ptr_then_read(8'h00);
        tick(50);
        check("to_pull_held", pull, 1'b1);
        check("to_addressed_held", addrd, 1'b1);
        tick(80);
        check("to_pull_released", pull, 1'b0);
        check("to_addressed_cleared", addrd, 1'b0);
        m_addr = 1'b0;
        m_active = 1'b0;
        stop_cond();
`endif

        // randomized transactions against the model
        for (int t = 0; t < 16; t++) begin
            op_v = $urandom_range(0, 2);
            if (op_v == 0) begin
                start_cond();
                send_byte(8'h90, 1'b1, ack_v);
                send_byte(pick_ptr(), 1'b0, ack_v);
                n_v = $urandom_range(0, 3);
                for (int k = 0; k < n_v; k++) send_byte(8'($urandom), 1'b0, ack_v);
                stop_cond();
            end else if (op_v == 1) begin
                if ($urandom_range(0, 1) == 1) begin
                    start_cond();
                    send_byte(8'h90, 1'b1, ack_v);
                    send_byte(pick_ptr(), 1'b0, ack_v);
                end
                temp = 16'($urandom);
                start_cond();
                send_byte(8'h91, 1'b1, ack_v);
                n_v = $urandom_range(1, 3);
                for (int k = 0; k < n_v; k++) recv_byte(k < n_v - 1, got_v);
                stop_cond();
            end else begin
                ad_v = 8'($urandom);
                while (ad_v[7:1] == 7'h48) ad_v = 8'($urandom);
                start_cond();
                send_byte(ad_v, 1'b1, ack_v);
                send_byte(8'($urandom), 1'b0, ack_v);
                stop_cond();
            end
        end

        tick(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
